// File: rtl/wb_mem_responder_if.sv
// Wishbone classic bus bundle between an initiator and wb_mem_responder.
// wb_err_o and its modport entries exist only when WB_RESP_ERR_EN is defined.
interface wb_mem_responder_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
);
  logic [ADDR_W-1:0] wb_adr_i;
  logic [DATA_W-1:0] wb_dat_i;
  logic              wb_we_i;
  logic              wb_stb_i;
  logic              wb_cyc_i;
  logic [STRB_W-1:0] wb_sel_i;
  logic [DATA_W-1:0] wb_dat_o;
  logic              wb_ack_o;
`ifdef WB_RESP_ERR_EN
  logic              wb_err_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i, wb_sel_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i, wb_sel_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );
`else
  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i, wb_sel_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i, wb_sel_i,
    output wb_dat_o, wb_ack_o
  );
`endif
endinterface

// File: rtl/wb_mem_responder.sv
// Wishbone classic responder backed by a small word-addressed register memory,
// with programmable wait states. Define WB_RESP_ERR_EN for error termination.
module wb_mem_responder #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int STRB_W      = DATA_W / 8,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  wb_mem_responder_if.slave wb
);

  localparam int                SHIFT    = $clog2(STRB_W);
  localparam int                IDX_W    = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
  localparam logic [7:0]        CNT_INIT = (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;
  localparam bit                NO_WAIT  = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t            state_r, next_state_s;
  logic [7:0]        cnt_r, cnt_nxt_s;
  logic [ADDR_W-1:0] adr_r;
  logic [DATA_W-1:0] wdat_r;
  logic [STRB_W-1:0] sel_r;
  logic              we_r;
  logic              ack_r, ack_nxt_s;
  logic [DATA_W-1:0] rdat_r, rdat_nxt_s;
  logic [DATA_W-1:0] mem_r [DEPTH];

  logic              req_s, capture_s, enter_ack_s, wr_en_s, rd_load_s, in_range_s;
  logic [ADDR_W-1:0] req_adr_s, word_idx_s;
  logic [DATA_W-1:0] req_dat_s;
  logic [STRB_W-1:0] req_sel_s;
  logic              req_we_s;
  logic [IDX_W-1:0]  mem_idx_s;
`ifdef WB_RESP_ERR_EN
  logic              err_r, err_nxt_s;
`endif

  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [STRB_W-1:0] sel
  );
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int b = 0; b < STRB_W; b++) begin
      if (sel[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
      else        res[b*8 +: 8] = old_w[b*8 +: 8];
    end
    return res;
  endfunction

  // Live bus fields in IDLE (zero-wait path), captured copies afterwards.
  always_comb begin
    req_s = wb.wb_cyc_i & wb.wb_stb_i;
    if (state_r == ST_IDLE) begin
      req_adr_s = wb.wb_adr_i;
      req_dat_s = wb.wb_dat_i;
      req_sel_s = wb.wb_sel_i;
      req_we_s  = wb.wb_we_i;
    end else begin
      req_adr_s = adr_r;
      req_dat_s = wdat_r;
      req_sel_s = sel_r;
      req_we_s  = we_r;
    end
    word_idx_s = req_adr_s >> SHIFT;
    mem_idx_s  = word_idx_s[IDX_W-1:0];
    in_range_s = (word_idx_s < DEPTH_A);
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= ST_IDLE;
    else        state_r <= next_state_s;
  end

  // Next-state logic; a dropped strobe or cycle during WAIT abandons the access.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_s) next_state_s = NO_WAIT ? ST_ACK : ST_WAIT;
        else       next_state_s = ST_IDLE;
      end
      ST_WAIT: begin
        if (!req_s)              next_state_s = ST_IDLE;
        else if (cnt_r == 8'd0)  next_state_s = ST_ACK;
        else                     next_state_s = ST_WAIT;
      end
      ST_ACK:  next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Output and datapath decode; everything lands on the edge that enters ACK.
  always_comb begin
    enter_ack_s = (next_state_s == ST_ACK);
    capture_s   = (state_r == ST_IDLE) && req_s;
    case (state_r)
      ST_IDLE: begin
        if (req_s && !NO_WAIT) cnt_nxt_s = CNT_INIT;
        else                   cnt_nxt_s = 8'd0;
      end
      ST_WAIT: begin
        if (req_s && (cnt_r != 8'd0)) cnt_nxt_s = cnt_r - 8'd1;
        else                          cnt_nxt_s = 8'd0;
      end
      default: cnt_nxt_s = 8'd0;
    endcase
    wr_en_s = enter_ack_s && req_we_s && in_range_s;
    if (in_range_s) rdat_nxt_s = mem_r[mem_idx_s];
    else            rdat_nxt_s = '0;
`ifdef WB_RESP_ERR_EN
    ack_nxt_s = enter_ack_s && in_range_s;
    err_nxt_s = enter_ack_s && !in_range_s;
    rd_load_s = enter_ack_s && (!req_we_s || !in_range_s);
`else
    ack_nxt_s = enter_ack_s;
    rd_load_s = enter_ack_s && !req_we_s;
`endif
  end

  // Registered responses, request capture, counter and memory array.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r  <= 8'd0;
      adr_r  <= '0;
      wdat_r <= '0;
      sel_r  <= '0;
      we_r   <= 1'b0;
      ack_r  <= 1'b0;
      rdat_r <= '0;
`ifdef WB_RESP_ERR_EN
      err_r  <= 1'b0;
`endif
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else begin
      cnt_r <= cnt_nxt_s;
      ack_r <= ack_nxt_s;
`ifdef WB_RESP_ERR_EN
      err_r <= err_nxt_s;
`endif
      if (capture_s) begin
        adr_r  <= wb.wb_adr_i;
        wdat_r <= wb.wb_dat_i;
        sel_r  <= wb.wb_sel_i;
        we_r   <= wb.wb_we_i;
      end
      if (wr_en_s)   mem_r[mem_idx_s] <= merge_bytes(mem_r[mem_idx_s], req_dat_s, req_sel_s);
      if (rd_load_s) rdat_r <= rdat_nxt_s;
    end
  end

  assign wb.wb_ack_o = ack_r;
  assign wb.wb_dat_o = rdat_r;
`ifdef WB_RESP_ERR_EN
  assign wb.wb_err_o = err_r;
`endif

endmodule

// File: tb/tb_wb_mem_responder.sv
// Directed bench for wb_mem_responder: three instances (0, 3 and 5 wait states)
// share one initiator; `which` selects the instance that sees the strobe.
module tb_wb_mem_responder;

  logic        clk;
  logic        reset;
  int          which;
  logic [15:0] m_adr;
  logic [31:0] m_dat;
  logic        m_we, m_stb, m_cyc;
  logic [3:0]  m_sel;
  logic        ack_m, err_m;
  logic [31:0] dat_m;
  int          total;
  int          bad;

  wb_mem_responder_if if0 ();
  wb_mem_responder_if if3 ();
  wb_mem_responder_if if5 ();

  wb_mem_responder #(.WAIT_CYCLES(0)) u_dut0 (.clk(clk), .reset(reset), .wb(if0));
  wb_mem_responder #(.WAIT_CYCLES(3)) u_dut3 (.clk(clk), .reset(reset), .wb(if3));
  wb_mem_responder #(.WAIT_CYCLES(5)) u_dut5 (.clk(clk), .reset(reset), .wb(if5));

  assign if0.wb_adr_i = m_adr;  assign if3.wb_adr_i = m_adr;  assign if5.wb_adr_i = m_adr;
  assign if0.wb_dat_i = m_dat;  assign if3.wb_dat_i = m_dat;  assign if5.wb_dat_i = m_dat;
  assign if0.wb_we_i  = m_we;   assign if3.wb_we_i  = m_we;   assign if5.wb_we_i  = m_we;
  assign if0.wb_sel_i = m_sel;  assign if3.wb_sel_i = m_sel;  assign if5.wb_sel_i = m_sel;
  assign if0.wb_stb_i = m_stb & (which == 0);
  assign if3.wb_stb_i = m_stb & (which == 3);
  assign if5.wb_stb_i = m_stb & (which == 5);
  assign if0.wb_cyc_i = m_cyc & (which == 0);
  assign if3.wb_cyc_i = m_cyc & (which == 3);
  assign if5.wb_cyc_i = m_cyc & (which == 5);

  assign ack_m = (which == 0) ? if0.wb_ack_o : (which == 3) ? if3.wb_ack_o : if5.wb_ack_o;
  assign dat_m = (which == 0) ? if0.wb_dat_o : (which == 3) ? if3.wb_dat_o : if5.wb_dat_o;
`ifdef WB_RESP_ERR_EN
  assign err_m = (which == 0) ? if0.wb_err_o : (which == 3) ? if3.wb_err_o : if5.wb_err_o;
`else
  assign err_m = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One classic cycle; lat = edges from the sampling edge up to the one that sees the response.
  task automatic xfer(input int w, input logic [15:0] adr, input logic [31:0] dat,
                      input logic we, input logic [3:0] sel, input bit scramble,
                      output logic [31:0] rd, output int lat,
                      output logic got_ack, output logic got_err);
    which = w;
    @(negedge clk);
    m_adr = adr; m_dat = dat; m_we = we; m_sel = sel;
    m_cyc = 1'b1; m_stb = 1'b1;
    lat = 0; got_ack = 1'b0; got_err = 1'b0; rd = 32'h0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack_m || err_m) begin
        got_ack = ack_m; got_err = err_m; rd = dat_m; lat = k;
        break;
      end
      if (scramble && k == 2) begin
        m_adr = 16'h0018; m_dat = 32'hFFFF_0000;
      end
    end
    m_cyc = 1'b0; m_stb = 1'b0;
  endtask

  task automatic do_write(input string tag, input int w, input logic [15:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] rd; int lat; logic a, e;
    xfer(w, adr, dat, 1'b1, sel, 1'b0, rd, lat, a, e);
    check({tag, "_ack"}, {31'h0, a}, 32'h1);
    check({tag, "_lat"}, lat, w + 1);
  endtask

  task automatic do_read(input string tag, input int w, input logic [15:0] adr,
                         input logic [31:0] exp);
    logic [31:0] rd; int lat; logic a, e;
    xfer(w, adr, 32'h0, 1'b0, 4'hF, 1'b0, rd, lat, a, e);
    check({tag, "_ack"}, {31'h0, a}, 32'h1);
    check({tag, "_data"}, rd, exp);
  endtask

  initial begin
    logic [31:0] rd;
    int          lat;
    logic        a, e, seen;
    total = 0; bad = 0; which = 3;
    m_adr = 16'h0; m_dat = 32'h0; m_we = 1'b0; m_sel = 4'h0; m_stb = 1'b0; m_cyc = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_ack", {31'h0, if3.wb_ack_o}, 32'h0);
    check("rst_dat", if3.wb_dat_o, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) do_read($sformatf("init_rd%0d", i), 3, 16'(i * 4), 32'h0);

    // Wait-state latency and byte-lane aliasing.
    xfer(3, 16'h0004, 32'hDEAD_BEEF, 1'b1, 4'hF, 1'b0, rd, lat, a, e);
    check("w3_wr_ack", {31'h0, a}, 32'h1);
    check("w3_wr_lat", lat, 4);
    xfer(3, 16'h0004, 32'h0, 1'b0, 4'h0, 1'b0, rd, lat, a, e);
    check("w3_rd_lat", lat, 4);
    check("w3_rd_data", rd, 32'hDEAD_BEEF);
    do_read("misalign", 3, 16'h0006, 32'hDEAD_BEEF);

    // Byte selects.
    do_write("sel_full", 3, 16'h0008, 32'hFFFF_FFFF, 4'hF);
    do_write("sel_0101", 3, 16'h0008, 32'h1122_3344, 4'b0101);
    do_read("sel_rd", 3, 16'h0008, 32'hFF22_FF44);
    do_write("sel_none", 3, 16'h0008, 32'h0000_0000, 4'h0);
    do_read("sel_none_rd", 3, 16'h0008, 32'hFF22_FF44);

    // Abort two cycles into a 5-wait write.
    which = 5;
    @(negedge clk);
    m_adr = 16'h000C; m_dat = 32'h1234_5678; m_we = 1'b1; m_sel = 4'hF;
    m_cyc = 1'b1; m_stb = 1'b1;
    seen = 1'b0;
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      if (ack_m) seen = 1'b1;
    end
    m_cyc = 1'b0;
    repeat (10) begin
      @(posedge clk); @(negedge clk);
      if (ack_m) seen = 1'b1;
    end
    m_stb = 1'b0;
    check("abort_noack", {31'h0, seen}, 32'h0);
    xfer(5, 16'h000C, 32'h0, 1'b0, 4'hF, 1'b0, rd, lat, a, e);
    check("abort_rd_lat", lat, 6);
    check("abort_rd_data", rd, 32'h0);

    // Address/data changes during WAIT are ignored.
    xfer(5, 16'h0014, 32'h0000_0A0A, 1'b1, 4'hF, 1'b1, rd, lat, a, e);
    check("hold_ack", {31'h0, a}, 32'h1);
    do_read("hold_rd14", 5, 16'h0014, 32'h0000_0A0A);
    do_read("hold_rd18", 5, 16'h0018, 32'h0);

    // Zero-wait instance and last word.
    do_write("w0_wr", 0, 16'h0004, 32'h1357_9BDF, 4'hF);
    xfer(0, 16'h0004, 32'h0, 1'b0, 4'hF, 1'b0, rd, lat, a, e);
    check("w0_rd_lat", lat, 1);
    check("w0_rd_data", rd, 32'h1357_9BDF);
    do_write("w0_last_wr", 0, 16'h003C, 32'h0F0F_0F0F, 4'hF);
    do_read("w0_last_rd", 0, 16'h003C, 32'h0F0F_0F0F);

    // Out-of-range index 16 must not alias onto word 0.
    do_write("oor_pre", 3, 16'h0000, 32'hCAFE_F00D, 4'hF);
    xfer(3, 16'h0040, 32'h5555_5555, 1'b1, 4'hF, 1'b0, rd, lat, a, e);
`ifdef WB_RESP_ERR_EN
    check("oor_wr_ack", {31'h0, a}, 32'h0);
    check("oor_wr_err", {31'h0, e}, 32'h1);
`else
    check("oor_wr_ack", {31'h0, a}, 32'h1);
    check("oor_wr_err", {31'h0, e}, 32'h0);
`endif
    check("oor_wr_lat", lat, 4);
    do_read("oor_word0", 3, 16'h0000, 32'hCAFE_F00D);
    xfer(3, 16'h0040, 32'h0, 1'b0, 4'hF, 1'b0, rd, lat, a, e);
`ifdef WB_RESP_ERR_EN
    check("oor_rd_err", {31'h0, e}, 32'h1);
`else
    check("oor_rd_ack", {31'h0, a}, 32'h1);
`endif
    check("oor_rd_data", rd, 32'h0);

    // Reset during WAIT of a write.
    do_read("pre_rst_rd", 3, 16'h0008, 32'hFF22_FF44);
    which = 3;
    @(negedge clk);
    m_adr = 16'h0010; m_dat = 32'hA5A5_A5A5; m_we = 1'b1; m_sel = 4'hF;
    m_cyc = 1'b1; m_stb = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_ack", {31'h0, if3.wb_ack_o}, 32'h0);
    check("mid_rst_dat3", if3.wb_dat_o, 32'h0);
    check("mid_rst_dat0", if0.wb_dat_o, 32'h0);
    m_cyc = 1'b0; m_stb = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    do_read("post_rst_rd10", 3, 16'h0010, 32'h0);
    do_read("post_rst_rd08", 3, 16'h0008, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
